// File: rtl/test_monitor.sv
// Self-test monitor: pulses a button reset, then watches exception
// retire codes for pass/fail markers and latches a verdict.
module test_monitor #(
  parameter int          NCH      = 2,
  parameter int          CODE_W   = 6,
  parameter int          PASS_BIT = 5,
  parameter int          FAIL_BIT = 4,
  parameter int unsigned POLL     = 10000,
  parameter int unsigned RST_DLY  = 5000,
  parameter int unsigned RST_W    = 500,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic [NCH-1:0]        ev_valid,
  input  logic [NCH*CODE_W-1:0] ev_code,
  output logic                  btn_rst,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  tmo,
  output logic [2:0]            hit_ch,
  output logic [31:0]           run_cycles
);

  typedef enum logic [2:0] {
    S_WAIT, S_PULSE, S_RUN, S_PASS, S_FAIL, S_TMO
  } state_t;

  state_t state, state_n;

  logic [31:0]    cnt;
  logic [31:0]    poll_cnt;
  logic [NCH-1:0] pass_f, fail_f;
  logic [NCH-1:0] ev_pass, ev_fail;
  logic [NCH-1:0] pass_any, fail_any;
  logic [31:0]    run_nxt;
  logic           tick, tmo_hit;

  function automatic logic [2:0] lowest(input logic [NCH-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

  // Decode per-channel pass/fail markers and poll/timeout conditions
  always_comb begin
    ev_pass = '0;
    ev_fail = '0;
    for (int i = 0; i < NCH; i++) begin
      ev_pass[i] = ev_valid[i] & ev_code[i*CODE_W+PASS_BIT];
      ev_fail[i] = ev_valid[i] & ev_code[i*CODE_W+FAIL_BIT];
    end
    pass_any = pass_f | ev_pass;
    fail_any = fail_f | ev_fail;
    run_nxt  = (run_cycles == '1) ? run_cycles : run_cycles + 32'd1;
    tick     = (state == S_RUN) && (poll_cnt == POLL - 1);
    tmo_hit  = (TIMEOUT != 0) && (run_nxt >= TIMEOUT);
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_WAIT;
    else         state <= state_n;
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    state_n = state;
    if (clear) begin
      state_n = S_WAIT;
    end else begin
      case (state)
        S_WAIT:
          if (cnt + 32'd1 >= RST_DLY) state_n = S_PULSE;
        S_PULSE:
          if (cnt + 32'd1 >= RST_W) state_n = S_RUN;
        S_RUN:
          if (tick && |fail_any)      state_n = S_FAIL;
          else if (tick && |pass_any) state_n = S_PASS;
          else if (tmo_hit)           state_n = S_TMO;
        default: state_n = state;
      endcase
    end
  end

  // Counters, sticky flags and verdict channel
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      poll_cnt   <= '0;
      run_cycles <= '0;
      pass_f     <= '0;
      fail_f     <= '0;
      hit_ch     <= '0;
    end else if (clear) begin
      cnt        <= '0;
      poll_cnt   <= '0;
      run_cycles <= '0;
      pass_f     <= '0;
      fail_f     <= '0;
      hit_ch     <= '0;
    end else begin
      if ((state == S_WAIT || state == S_PULSE) && state_n == state)
        cnt <= cnt + 32'd1;
      else
        cnt <= '0;
      if (state == S_RUN) begin
        run_cycles <= run_nxt;
        poll_cnt   <= tick ? '0 : poll_cnt + 32'd1;
        pass_f     <= pass_any;
        fail_f     <= fail_any;
        if (state_n == S_FAIL)      hit_ch <= lowest(fail_any);
        else if (state_n == S_PASS) hit_ch <= lowest(pass_any);
      end
    end
  end

  // Outputs decoded from state only
  always_comb begin
    btn_rst = 1'b0;
    pass    = 1'b0;
    fail    = 1'b0;
    tmo     = 1'b0;
    case (state)
      S_PULSE: btn_rst = 1'b1;
      S_PASS:  pass    = 1'b1;
      S_FAIL:  fail    = 1'b1;
      S_TMO:   tmo     = 1'b1;
      default: ;
    endcase
    done = pass | fail | tmo;
  end

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor: directed reset/pulse/verdict scenarios plus
// random event streams judged by a cycle-count reference model.
module tb_test_monitor;

  localparam int          NCH  = 2;
  localparam int          CW   = 6;
  localparam int          PB   = 5;
  localparam int          FB   = 4;
  localparam int unsigned PL   = 8;
  localparam int unsigned DLY  = 10;
  localparam int unsigned W    = 4;
  localparam int unsigned TO   = 20;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              clear = 1'b0;
  logic [NCH-1:0]    ev_valid = '0;
  logic [NCH*CW-1:0] ev_code = '0;
  logic              btn_rst, done, pass, fail, tmo;
  logic [2:0]        hit_ch;
  logic [31:0]       run_cycles;

  int total = 0;
  int bad = 0;

  test_monitor #(
    .NCH(NCH), .CODE_W(CW), .PASS_BIT(PB), .FAIL_BIT(FB),
    .POLL(PL), .RST_DLY(DLY), .RST_W(W), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .resetn(resetn), .clear(clear),
    .ev_valid(ev_valid), .ev_code(ev_code),
    .btn_rst(btn_rst), .done(done), .pass(pass), .fail(fail),
    .tmo(tmo), .hit_ch(hit_ch), .run_cycles(run_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] low_idx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++)
      if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_btn"}, 32'(btn_rst), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_vrd"}, {29'd0, pass, fail, tmo}, 0);
    chk({tag, "_hit"}, 32'(hit_ch), 0);
    chk({tag, "_cyc"}, run_cycles, 0);
  endtask

  // From WAIT start: button pulse expected on edges DLY..DLY+W-1
  task automatic seq_to_run(input string tag);
    for (int k = 1; k <= int'(DLY + W); k++) begin
      step();
      chk($sformatf("%s_btn_k%0d", tag, k), 32'(btn_rst),
          32'((k >= int'(DLY)) && (k < int'(DLY + W))));
      chk($sformatf("%s_done_k%0d", tag, k), 32'(done), 0);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_idle("clear");
  endtask

  // Run phase judged by model: verdict only at multiples of the poll
  // period, fail beats pass, timeout at TO run cycles otherwise.
  task automatic run_phase(input string tag, input bit rnd,
                           input int dr, input logic [NCH-1:0] dv,
                           input logic [NCH*CW-1:0] dc);
    logic [NCH-1:0]    mp, mf, v;
    logic [NCH*CW-1:0] c;
    logic              ep, ef, et;
    logic [2:0]        eh;
    int                r;
    bit                fin;
    mp = '0; mf = '0; ep = 0; ef = 0; et = 0; eh = '0;
    r = 0; fin = 0;
    while (!fin && r < 100) begin
      r++;
      v = '0;
      c = '0;
      if (rnd) begin
        for (int ch = 0; ch < NCH; ch++) begin
          v[ch] = ($urandom_range(0, 9) == 0);
          c[ch*CW +: CW] = CW'($urandom);
        end
      end else if (r == dr) begin
        v = dv;
        c = dc;
      end
      ev_valid = v;
      ev_code = c;
      step();
      ev_valid = '0;
      ev_code = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        if (v[ch] && c[ch*CW+PB]) mp[ch] = 1'b1;
        if (v[ch] && c[ch*CW+FB]) mf[ch] = 1'b1;
      end
      if (r % int'(PL) == 0 && mf != 0) begin
        ef = 1; eh = low_idx(mf); fin = 1;
      end else if (r % int'(PL) == 0 && mp != 0) begin
        ep = 1; eh = low_idx(mp); fin = 1;
      end else if (r == int'(TO)) begin
        et = 1; fin = 1;
      end
      chk($sformatf("%s_r%0d_vrd", tag, r),
          {28'd0, done, pass, fail, tmo}, {28'd0, fin, ep, ef, et});
      chk($sformatf("%s_r%0d_cyc", tag, r), run_cycles, 32'(r));
      chk($sformatf("%s_r%0d_hit", tag, r), 32'(hit_ch), 32'(eh));
      chk($sformatf("%s_r%0d_btn", tag, r), 32'(btn_rst), 0);
    end
    chk({tag, "_bound"}, 32'(fin), 1);
    for (int h = 0; h < 3; h++) begin
      ev_valid = NCH'($urandom);
      ev_code = (NCH*CW)'($urandom);
      step();
      chk($sformatf("%s_hold%0d_vrd", tag, h),
          {28'd0, done, pass, fail, tmo}, {28'd0, fin, ep, ef, et});
      chk($sformatf("%s_hold%0d_cyc", tag, h), run_cycles, 32'(r));
      chk($sformatf("%s_hold%0d_hit", tag, h), 32'(hit_ch), 32'(eh));
    end
    ev_valid = '0;
    ev_code = '0;
  endtask

  initial begin
    #2;
    chk_idle("rst");
    step();
    chk_idle("rst_hold");
    resetn = 1'b1;

    seq_to_run("boot");
    run_phase("pass1", 0, 2, 2'b10, {6'h20, 6'h00});
    chk("pass1_pass", 32'(pass), 1);
    chk("pass1_hit", 32'(hit_ch), 1);
    chk("pass1_cyc", run_cycles, 8);

    do_clear();
    seq_to_run("clr1");
    run_phase("fail1", 0, 3, 2'b11, {6'h10, 6'h20});
    chk("fail1_fail", 32'(fail), 1);
    chk("fail1_pass", 32'(pass), 0);
    chk("fail1_hit", 32'(hit_ch), 1);

    do_clear();
    seq_to_run("clr2");
    run_phase("tmo1", 0, 0, 2'b00, '0);
    chk("tmo1_vrd", {29'd0, done, tmo, hit_ch == 3'd0}, 32'h7);
    chk("tmo1_cyc", run_cycles, 20);

    // Reset mid-pulse: button drops at once, sequence restarts
    do_clear();
    for (int k = 1; k <= int'(DLY) + 1; k++) step();
    chk("midpulse_btn_before", 32'(btn_rst), 1);
    resetn = 1'b0;
    #1;
    chk("midpulse_btn_async", 32'(btn_rst), 0);
    step();
    resetn = 1'b1;
    chk_idle("midpulse");
    seq_to_run("midpulse_seq");

    // Reset mid-run with a pass flag set: flag lost, timeout follows
    for (int r = 1; r <= 4; r++) begin
      if (r == 2) begin
        ev_valid = 2'b01;
        ev_code = {6'h00, 6'h20};
      end
      step();
      ev_valid = '0;
      ev_code = '0;
    end
    resetn = 1'b0;
    #1;
    chk_idle("midrun");
    step();
    resetn = 1'b1;
    seq_to_run("midrun_seq");
    run_phase("midrun_run", 0, 0, 2'b00, '0);
    chk("midrun_tmo", 32'(tmo), 1);

    for (int t = 0; t < 8; t++) begin
      do_clear();
      seq_to_run($sformatf("rnd%0d_seq", t));
      run_phase($sformatf("rnd%0d", t), 1, 0, '0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
